// File: rtl/led_pulse_driver_if.sv
// Signal bundle between core logic (master) and the LED/buzzer pulse driver (slave).
interface led_pulse_driver_if #(
    parameter int PEND_W = 4
) ();
    // event_in is a one-cycle strobe with no backpressure: every sampled high is one
    // event, and the driver raises dropped when it cannot keep one.
    logic              event_in;
    logic              out_pulse;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              dropped;

    modport master (output event_in, input out_pulse, busy, pending, dropped);
    modport slave  (input event_in, output out_pulse, busy, pending, dropped);
endinterface

// File: rtl/led_pulse_driver.sv
// Turns single-cycle event strobes into pulses with guaranteed high time and low gap,
// queueing events that arrive mid-pulse in a saturating counter.
module led_pulse_driver #(
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int CNT_W      = 24,
    parameter int PEND_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pulse_driver_if.slave    bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              dropped_q, dropped_d;
    logic              out_pulse_q, busy_q;
    logic              consume, deq, enq;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        consume = 1'b0;
        deq     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.event_in) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                    consume = 1'b1;
                end
            end
            S_ON: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_OFF;
                    cnt_d   = OFF_LOAD;
                end
            end
            S_OFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pending_q != '0) begin
                    // Queued events go first; a live strobe this edge is then queued.
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                    deq     = 1'b1;
                end else if (bus.event_in) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                    consume = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign enq = bus.event_in && !consume;

    always_comb begin
        pending_d = pending_q;
        dropped_d = 1'b0;
        if (enq && !deq) begin
            if (pending_q == PEND_MAX) begin
                dropped_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (deq && !enq) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pending_q   <= '0;
            dropped_q   <= 1'b0;
            out_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            dropped_q   <= dropped_d;
            out_pulse_q <= (state_d == S_ON);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.out_pulse = out_pulse_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.dropped   = dropped_q;
    assign dbg_state_o   = state_q;

endmodule
